// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: default widths, owner encoding, tracker entry.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF     = 24;
    localparam int DATA_W_DEF     = 16;
    localparam int STARVE_MAX_DEF = 3;

    // Which requester a memory access belongs to
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // One stage of the in-flight read tracker
    typedef struct packed {
        logic   vld;
        owner_e own;
    } trk_t;

endpackage

// File: rtl/mem_port_arbiter_prio.sv
// Fixed-priority grant for load/store over fetch, with an anti-starvation override for fetch.
// Latency: purely combinational, grants in the same cycle as the requests.
// Backpressure: a requester that is not granted simply keeps its request high.
module mem_arb_prio #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic             if_req,
    input  logic             ls_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             if_gnt,
    output logic             ls_gnt
);

    // Load/store wins unless fetch has already waited STARVE_MAX load/store grants
    always_comb begin
        ls_gnt = ls_req && !(if_req && (starve_cnt == CNT_W'(STARVE_MAX)));
        if_gnt = if_req && !ls_gnt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store onto one registered memory port and routes read data back.
// Latency: grant same cycle, memory port N+1, rvalid/rdata N+2 for a read granted in N.
// Backpressure: ungranted requests wait; one grant per cycle, reads fully pipelined.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              WriteEnable,
    input  logic [DATA_W-1:0] ReadData
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    trk_t              trk0_q, trk0_d;
    trk_t              trk1_q, trk1_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] ls_rdata_q, ls_rdata_d;
    logic              if_gnt_raw, ls_gnt_raw;

    mem_arb_prio #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_prio (
        .if_req     (if_req),
        .ls_req     (ls_req),
        .starve_cnt (starve_cnt_q),
        .if_gnt     (if_gnt_raw),
        .ls_gnt     (ls_gnt_raw)
    );

    // Grants are combinational but must stay low while reset is held
    assign if_gnt = if_gnt_raw & rst_n;
    assign ls_gnt = ls_gnt_raw & rst_n;

    // Next-state: starvation counter, memory port, read tracker and per-owner read data
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req || if_gnt) begin
            starve_cnt_d = '0;
        end else if (ls_gnt && (starve_cnt_q != CNT_W'(STARVE_MAX))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (if_gnt) begin
            addr_d = if_addr;
        end else if (ls_gnt) begin
            addr_d  = ls_addr;
            wdata_d = ls_wdata;
            we_d    = ls_we;
        end

        // Stage 0 marks a read on the port this cycle; stage 1 lines up with rvalid
        trk0_d.vld = if_gnt || (ls_gnt && !ls_we);
        trk0_d.own = ls_gnt ? OWN_LS : OWN_IF;
        trk1_d     = trk0_q;

        // ReadData belongs to the read that stage 0 describes; only its owner updates
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        if (trk0_q.vld && (trk0_q.own == OWN_IF)) begin
            if_rdata_d = ReadData;
        end
        if (trk0_q.vld && (trk0_q.own == OWN_LS)) begin
            ls_rdata_d = ReadData;
        end
    end

    // State registers; reset discards any reads still in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            trk0_q       <= '{vld: 1'b0, own: OWN_IF};
            trk1_q       <= '{vld: 1'b0, own: OWN_IF};
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            trk0_q       <= trk0_d;
            trk1_q       <= trk1_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
        end
    end

    assign Address     = addr_q;
    assign WriteData   = wdata_q;
    assign WriteEnable = we_q;
    assign if_rvalid   = trk1_q.vld && (trk1_q.own == OWN_IF);
    assign ls_rvalid   = trk1_q.vld && (trk1_q.own == OWN_LS);
    assign if_rdata    = if_rdata_q;
    assign ls_rdata    = ls_rdata_q;

endmodule
